// File: rtl/res_buffer_ctrl.sv
// res_buffer_ctrl: feeds an N-result job into the 4-entry row buffer and writes each filled row out.
// Latency: a push lands in the buffer on the accepting edge; a full row costs 4 push + 1 write + 1 clear cycles.
// Backpressure: resReady is high only in COLLECT; WRITE holds wrReq (and a stable wrAddr) until wrAck.
// Ports: start/numRes launch a job; resValid/resIn/resReady is the producer handshake;
//   bufEn/bufData/bufClear/bufFull drive and observe the buffer; wrReq/wrAddr/wrAck is the
//   row write handshake; busy/done/err report job status (err is sticky until the next start).
module res_buffer_ctrl #(
  parameter int          CNT_W     = 10,
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  numRes,
  input  logic              resValid,
  input  logic [7:0]        resIn,
  output logic              resReady,
  output logic              bufEn,
  output logic [7:0]        bufData,
  output logic              bufClear,
  input  logic              bufFull,
  output logic              wrReq,
  output logic [ADDR_W-1:0] wrAddr,
  input  logic              wrAck,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_PAD,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        lane;
  logic              push;
  logic              last_lane;

  // A push happens on every PAD cycle and on accepted producer beats in COLLECT.
  assign push      = ((state == S_COLLECT) && resValid) || (state == S_PAD);
  assign last_lane = (lane == 2'd3);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job bookkeeping: result countdown, buffer lane, row address and the sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      lane      <= '0;
      wrAddr    <= BASE;
      err       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        remaining <= numRes;
        lane      <= '0;
        wrAddr    <= BASE;
        err       <= 1'b0;
      end
      if (push) begin
        lane <= lane + 2'd1;
        if (state == S_COLLECT) begin
          remaining <= remaining - CNT_W'(1);
        end
        // The 4th push of a row must see the buffer holding three entries already.
        if (last_lane && !bufFull) begin
          err <= 1'b1;
        end
      end
      if ((state == S_WRITE) && wrAck) begin
        wrAddr <= wrAddr + ADDR_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (numRes == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (resValid) begin
          // A row that fills on the last result goes straight to WRITE without padding.
          if (last_lane) begin
            state_nxt = S_WRITE;
          end else if (remaining == CNT_W'(1)) begin
            state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (last_lane) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wrAck) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_nxt = (remaining == '0) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs: Moore strobes, except the COLLECT push which follows resValid/resIn directly.
  always_comb begin
    resReady = (state == S_COLLECT);
    bufEn    = push;
    bufData  = ((state == S_COLLECT) && resValid) ? resIn : 8'h00;
    bufClear = (state == S_CLEAR);
    wrReq    = (state == S_WRITE);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

endmodule

// File: tb/tb_res_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_res_buffer_ctrl;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 4;   // narrow address so a modest job wraps the row address
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  numRes = '0;
  logic              resValid = 1'b0;
  logic [7:0]        resIn = '0;
  logic              resReady;
  logic              bufEn;
  logic [7:0]        bufData;
  logic              bufClear;
  logic              bufFull;
  logic              wrReq;
  logic [ADDR_W-1:0] wrAddr;
  logic              wrAck = 1'b0;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  res_buffer_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .numRes(numRes),
    .resValid(resValid), .resIn(resIn), .resReady(resReady),
    .bufEn(bufEn), .bufData(bufData), .bufClear(bufClear), .bufFull(bufFull),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrAck(wrAck),
    .busy(busy), .done(done), .err(err)
  );

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- result buffer model (4 entries, 2-bit count) ----------------
  logic [7:0] bent [4];
  logic [1:0] bcnt;
  bit         full0 = 1'b0;   // forces bufFull low for the fault check

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      for (int i = 0; i < 4; i++) bent[i] <= '0;
    end else if (bufClear) begin
      bcnt <= '0;
      for (int i = 0; i < 4; i++) bent[i] <= '0;
    end else if (bufEn) begin
      bent[bcnt] <= bufData;
      bcnt       <= bcnt + 2'd1;
    end
  end
  assign bufFull = !full0 && (bcnt == 2'd3);

  // ---------------- producer ----------------
  int         pmode = 0;      // 0: valid whenever data, 1: toggle, 2: random
  logic [7:0] prod_q[$];
  bit         fire;
  bit         tog = 1'b0;

  always begin
    @(negedge clk);
    fire = resValid && resReady;
    @(posedge clk);
    #1;
    if (fire && prod_q.size() > 0) void'(prod_q.pop_front());
    tog = !tog;
    if (prod_q.size() > 0) begin
      resIn = prod_q[0];
      case (pmode)
        0:       resValid = 1'b1;
        1:       resValid = tog;
        default: resValid = ($urandom_range(0, 9) < 7);
      endcase
    end else begin
      // Idle garbage: must never be accepted.
      resValid = 1'($urandom_range(0, 1));
      resIn    = 8'($urandom);
    end
  end

  // ---------------- write acknowledger ----------------
  int ack_mode = 3;   // 0: random, 1: after ack_d cycles of wrReq, 2: never, 3: always high
  int ack_d    = 2;
  int ack_cnt  = 0;

  always begin
    @(negedge clk);
    ack_cnt = wrReq ? ack_cnt + 1 : 0;
    @(posedge clk);
    #1;
    case (ack_mode)
      0:       wrAck = ($urandom_range(0, 2) == 0);
      1:       wrAck = (ack_cnt == ack_d);
      2:       wrAck = 1'b0;
      default: wrAck = 1'b1;
    endcase
  end

  // ---------------- reference model: what a job must produce ----------------
  logic [7:0]        jv[$];        // values of the job being launched
  logic [7:0]        exp_push[$];  // every byte that must be pushed, pads included
  logic [31:0]       exp_row[$];   // row contents, entry 0 in the top byte
  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] la[$];        // observed write addresses
  logic [31:0]       ld[$];        // observed row contents
  int npush, npad, nwr, nclr, ndone;
  bit chk_en = 1'b0;
  bit err_skip = 1'b0;
  bit fault_job = 1'b0;

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (!bufEn) chk("bufdata_zero_without_en", 32'(bufData), 0);
      if (resReady) chk("bufen_follows_valid", 32'(bufEn), 32'(resValid));
      if (resReady && resValid) chk("bufdata_is_resin", 32'(bufData), 32'(resIn));
      if (!busy) chk("strobes_low_when_idle", 32'({resReady, bufEn, wrReq, bufClear, done}), 0);
      if (!err_skip) chk("err_low", 32'(err), 0);
      if (bufEn) begin
        chk("push_expected", 32'(exp_push.size() > 0), 1);
        if (exp_push.size() > 0) chk("push_data", 32'(bufData), 32'(exp_push.pop_front()));
        npush++;
        if (!resReady) npad++;
      end
      if (wrReq) begin
        chk("row_expected", 32'(exp_row.size() > 0), 1);
        if (exp_row.size() > 0) begin
          chk("wr_addr", 32'(wrAddr), 32'(exp_addr[0]));
          chk("row_data", {bent[0], bent[1], bent[2], bent[3]}, exp_row[0]);
          if (wrAck) begin
            la.push_back(wrAddr);
            ld.push_back({bent[0], bent[1], bent[2], bent[3]});
            void'(exp_row.pop_front());
            void'(exp_addr.pop_front());
            nwr++;
          end
        end
      end
      if (bufClear) nclr++;
      if (done) begin
        chk("done_pushes_left", exp_push.size(), 0);
        chk("done_rows_left", exp_row.size(), 0);
        chk("done_buf_count_zero", 32'(bcnt), 0);
        ndone++;
      end
    end
  end

  // ---------------- job tasks ----------------
  task automatic launch(input int n);
    int g;
    int pad;
    logic [7:0] p[$];
    g = 0;
    @(negedge clk);
    while (busy && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("idle_before_start", 32'(busy), 0);
    npush = 0; npad = 0; nwr = 0; nclr = 0; ndone = 0;
    la.delete(); ld.delete();
    exp_push.delete(); exp_row.delete(); exp_addr.delete();
    for (int i = 0; i < n; i++) begin
      p.push_back(jv[i]);
      prod_q.push_back(jv[i]);
    end
    pad = (4 - n % 4) % 4;
    for (int i = 0; i < pad; i++) p.push_back(8'h00);
    for (int r = 0; r < p.size() / 4; r++) begin
      exp_row.push_back({p[4*r], p[4*r+1], p[4*r+2], p[4*r+3]});
      exp_addr.push_back(ADDR_W'((BASE + r) % (1 << ADDR_W)));
    end
    foreach (p[i]) exp_push.push_back(p[i]);
    @(posedge clk);
    #1;
    start  = 1'b1;
    numRes = CNT_W'(n);
  endtask

  // k = index of the cycle in which done is seen, counting the start cycle as 0.
  task automatic wait_done(input bit spur, output int k);
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 3000) begin
      @(posedge clk);
      #1;
      if (spur && ($urandom_range(0, 1) == 1)) begin
        start  = 1'b1;
        numRes = CNT_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("busy_after_start", 32'(busy), 1);
        chk("err_cleared_by_start", 32'(err), 0);
        err_skip = fault_job;
      end
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(seen), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int n, input bit spur, output int k);
    launch(n);
    wait_done(spur, k);
    repeat (2) @(negedge clk);
    chk("done_single_pulse", ndone, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int g;
    int n;

    #12;
    chk("rst_outputs", 32'({resReady, bufEn, bufData, bufClear, wrReq, busy, done, err}), 0);
    chk("rst_wraddr", 32'(wrAddr), BASE);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // One full row, ack two cycles after wrReq rises: 4 push + 3 write + clear + done.
    pmode = 0; ack_mode = 1; ack_d = 2;
    jv = {8'h11, 8'h22, 8'h33, 8'h44};
    run_job(4, 0, k);
    chk("t1_cycles", k, 9);
    chk("t1_writes", nwr, 1);
    chk("t1_addr", 32'(la[0]), 0);
    chk("t1_row", ld[0], 32'h11223344);
    chk("t1_clears", nclr, 1);
    chk("t1_err", 32'(err), 0);

    // Six results: second row padded with two zero pushes, ack immediate.
    ack_mode = 3;
    jv = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_job(6, 0, k);
    chk("t2_cycles", k, 13);
    chk("t2_writes", nwr, 2);
    chk("t2_addr0", 32'(la[0]), 0);
    chk("t2_row0", ld[0], 32'h01020304);
    chk("t2_addr1", 32'(la[1]), 1);
    chk("t2_row1", ld[1], 32'h05060000);
    chk("t2_pads", npad, 2);
    chk("t2_buf_count", 32'(bcnt), 0);

    // A following job starts again at the base address; 4 push + write + clear + done.
    jv = {8'hA0, 8'hB1, 8'hC2, 8'hD3};
    run_job(4, 0, k);
    chk("t3_cycles", k, 7);
    chk("t3_addr", 32'(la[0]), 0);
    chk("t3_pads", npad, 0);

    // Empty job: done in the cycle right after start, nothing pushed or written.
    jv.delete();
    run_job(0, 0, k);
    chk("t4_cycles", k, 1);
    chk("t4_pushes", npush, 0);
    chk("t4_writes", nwr, 0);

    // Producer gaps with spurious starts while busy.
    pmode = 1;
    jv = {8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
    run_job(5, 1, k);
    chk("t5_pushes", npush, 8);
    chk("t5_pads", npad, 3);
    chk("t5_writes", nwr, 2);
    chk("t5_row1", ld[1], 32'h9E000000);

    // Buffer never reports full on the 4th push: err sets and holds until the next start.
    pmode = 0; fault_job = 1'b1; err_skip = 1'b1; full0 = 1'b1;
    jv = {8'h10, 8'h20, 8'h30, 8'h40};
    run_job(4, 0, k);
    chk("t6_cycles", k, 7);
    chk("t6_err_set", 32'(err), 1);
    full0 = 1'b0; fault_job = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 1);
    jv = {8'h01, 8'h02, 8'h03, 8'h04};
    run_job(4, 0, k);
    chk("t6_err_after_clean_job", 32'(err), 0);

    // Reset while the second row is in WRITE.
    ack_mode = 3;
    jv.delete();
    for (int i = 0; i < 8; i++) jv.push_back(8'($urandom));
    launch(8);
    @(posedge clk);
    #1;
    start = 1'b0;
    g = 0;
    while (nwr < 1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    ack_mode = 2;
    g = 0;
    while (!wrReq && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("t7_wrreq_seen", 32'(wrReq), 1);
    chk("t7_addr_row1", 32'(wrAddr), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_outputs", 32'({resReady, bufEn, bufData, bufClear, wrReq, busy, done, err}), 0);
    chk("t7_rst_wraddr", 32'(wrAddr), BASE);
    prod_q.delete(); exp_push.delete(); exp_row.delete(); exp_addr.delete();
    @(negedge clk);
    rst = 1'b0;
    ack_mode = 3;
    jv = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_job(4, 0, k);
    chk("t7_restart_cycles", k, 7);
    chk("t7_restart_addr", 32'(la[0]), 0);

    // 70 results = 18 rows, so the 4-bit row address wraps.
    jv.delete();
    for (int i = 0; i < 70; i++) jv.push_back(8'($urandom));
    run_job(70, 0, k);
    chk("t8_writes", nwr, 18);
    chk("t8_addr15", 32'(la[15]), 15);
    chk("t8_addr16_wrap", 32'(la[16]), 0);
    chk("t8_addr17", 32'(la[17]), 1);

    // Random jobs: random producer gaps, random acks, spurious starts.
    pmode = 2; ack_mode = 0;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 40);
      jv.delete();
      for (int i = 0; i < n; i++) jv.push_back(8'($urandom));
      run_job(n, 1, k);
      chk("rand_writes", nwr, (n + 3) / 4);
      chk("rand_clears", nclr, (n + 3) / 4);
      chk("rand_pushes", npush, 4 * ((n + 3) / 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
